// File: rtl/cluster_id_remapper.sv
// cluster_id_remapper: compacts wide AXI IDs into a narrow slot-index ID space.
// Optional stall statistics counter enabled by CLUSTER_ID_REMAP_STALL_CNT_EN.
module cluster_id_remapper #(
    parameter int InIdWidth  = 4,
    parameter int OutIdWidth = 2,
    parameter int MaxTxns    = 8,
    parameter int CntWidth   = $clog2(MaxTxns + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [InIdWidth-1:0]  req_id_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [OutIdWidth-1:0] req_id_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [OutIdWidth-1:0] rsp_id_i,
    input  logic                  rsp_last_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [InIdWidth-1:0]  rsp_id_o,
    output logic [OutIdWidth:0]   free_slots_o,
    output logic                  busy_o,
    output logic [15:0]           stall_cnt_o
);

    localparam int NumSlots = 2 ** OutIdWidth;

    logic [NumSlots-1:0] slot_valid;
    logic [InIdWidth-1:0] slot_id [NumSlots];
    logic [CntWidth-1:0] slot_cnt [NumSlots];

    logic                  hit;
    logic [OutIdWidth-1:0] hit_idx;
    logic                  free_found;
    logic [OutIdWidth-1:0] free_idx;
    logic [OutIdWidth-1:0] sel_idx;
    logic                  stall;
    logic                  issue;
    logic                  rsp_done;
    logic [NumSlots-1:0]   inc;
    logic [NumSlots-1:0]   dec;
    logic [OutIdWidth:0]   free_cnt;

    // Lookup: matching slot and lowest free slot (descending scan keeps lowest).
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (slot_valid[i] && slot_id[i] == req_id_i) begin
                hit     = 1'b1;
                hit_idx = OutIdWidth'(i);
            end
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = OutIdWidth'(i);
            end
        end
    end

    assign sel_idx = hit ? hit_idx : free_idx;
    assign stall   = hit ? (slot_cnt[hit_idx] == CntWidth'(MaxTxns))
                         : !free_found;

    assign req_valid_o = req_valid_i & ~stall;
    assign req_ready_o = req_ready_i & ~stall;
    assign req_id_o    = sel_idx;

    assign rsp_valid_o = rsp_valid_i;
    assign rsp_ready_o = rsp_ready_i;
    assign rsp_id_o    = slot_id[rsp_id_i];

    assign issue    = req_valid_o & req_ready_i;
    assign rsp_done = rsp_valid_i & rsp_ready_i & rsp_last_i;

    // Per-slot increment/decrement strobes; decrement never underflows.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NumSlots; i++) begin
            inc[i] = issue && (sel_idx == OutIdWidth'(i));
            dec[i] = rsp_done && (rsp_id_i == OutIdWidth'(i))
                     && (slot_cnt[i] != '0);
        end
    end

    // Occupancy summary from the registered valid bits.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NumSlots; i++) begin
            free_cnt = free_cnt + {{OutIdWidth{1'b0}}, ~slot_valid[i]};
        end
    end

    assign free_slots_o = free_cnt;
    assign busy_o       = |slot_valid;

    // Slot table update; a simultaneous issue keeps the slot alive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                slot_id[i]  <= '0;
                slot_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (inc[i] && !dec[i]) begin
                    slot_cnt[i] <= slot_cnt[i] + CntWidth'(1);
                end else if (dec[i] && !inc[i]) begin
                    slot_cnt[i] <= slot_cnt[i] - CntWidth'(1);
                end
                if (inc[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_id[i]    <= req_id_i;
                end else if (dec[i] && slot_cnt[i] == CntWidth'(1)) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // A response must target a slot with outstanding transactions.
    a_rsp_legal : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (rsp_valid_i && rsp_ready_i) |->
            (slot_valid[rsp_id_i] && slot_cnt[rsp_id_i] != '0)
    );

`ifdef CLUSTER_ID_REMAP_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles where a request is held back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (req_valid_i && stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_cluster_id_remapper.sv
// Scoreboard bench for cluster_id_remapper: directed requests/responses,
// expected IDs queued at issue time and checked by a negedge monitor.
module tb_cluster_id_remapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_id_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [1:0]  req_id_o;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [1:0]  rsp_id_i;
    logic        rsp_last_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [3:0]  rsp_id_o;
    logic [2:0]  free_slots_o;
    logic        busy_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_stall;

    logic [1:0] req_q [$];
    logic [3:0] rsp_q [$];

    always #5 clk = ~clk;

    cluster_id_remapper dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_id_o     (req_id_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_ready_o  (rsp_ready_o),
        .rsp_id_i     (rsp_id_i),
        .rsp_last_i   (rsp_last_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .free_slots_o (free_slots_o),
        .busy_o       (busy_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a handshake.
    always @(negedge clk) begin
        if (!rst && req_valid_o && req_ready_i) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected got %0d expected none", req_id_o);
            end else begin
                chk("req_id", int'(req_id_o), int'(req_q.pop_front()));
            end
        end
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got %0d expected none", rsp_id_o);
            end else begin
                chk("rsp_id", int'(rsp_id_o), int'(rsp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] id, input logic [1:0] exp);
        req_valid_i = 1'b1;
        req_id_i    = id;
        req_q.push_back(exp);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic rsp(input logic [1:0] id, input logic last,
                       input logic [3:0] exp);
        rsp_valid_i = 1'b1;
        rsp_id_i    = id;
        rsp_last_i  = last;
        rsp_q.push_back(exp);
        tick();
        rsp_valid_i = 1'b0;
        rsp_last_i  = 1'b0;
    endtask

    task automatic state(input string name, input int free, input int busy);
        @(negedge clk);
        chk({name, "_free"}, int'(free_slots_o), free);
        chk({name, "_busy"}, int'(busy_o), busy);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef CLUSTER_ID_REMAP_STALL_CNT_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_id_i    = '0;
        req_ready_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_id_i    = '0;
        rsp_last_i  = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_cnt", int'(stall_cnt_o), 0);
        chk("rst_req_valid", int'(req_valid_o), 0);
        state("rst", 4, 0);

        // First allocation
        req(4'hA, 2'd0);
        state("first", 3, 1);

        // Fill the table
        req(4'h5, 2'd1);
        req(4'hA, 2'd0);
        req(4'hC, 2'd2);
        req(4'h3, 2'd3);
        state("full", 0, 1);

        // Miss with no free slot stalls; hold for 10 cycles
        req_valid_i = 1'b1;
        req_id_i    = 4'h7;
        @(negedge clk);
        chk("full_req_ready", int'(req_ready_o), 0);
        chk("full_req_valid", int'(req_valid_o), 0);
        repeat (10) @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("stall_cnt", int'(stall_cnt_o), exp_stall);
        tick();

        // Non-last beat keeps the slot, last beat frees it
        rsp(2'd1, 1'b0, 4'h5);
        state("nonlast", 0, 1);
        rsp(2'd1, 1'b1, 4'h5);
        state("last", 1, 1);
        rsp(2'd2, 1'b1, 4'hC);
        rsp(2'd3, 1'b1, 4'h3);
        state("drain3", 3, 1);

        // Slot 0 (ID A) goes from cnt 2 up to MaxTxns
        for (int i = 0; i < 6; i++) begin
            req(4'hA, 2'd0);
        end
        req_valid_i = 1'b1;
        req_id_i    = 4'hA;
        @(negedge clk);
        chk("max_stall", int'(req_valid_o), 0);
        tick();
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd0;
        rsp_last_i  = 1'b1;
        rsp_q.push_back(4'hA);
        @(negedge clk);
        chk("max_stall_rsp", int'(req_valid_o), 0);
        tick();
        rsp_valid_i = 1'b0;
        rsp_last_i  = 1'b0;
        req_q.push_back(2'd0);
        @(negedge clk);
        chk("max_unstall", int'(req_valid_o), 1);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1;
        #1;
        chk("max_again", int'(req_valid_o), 0);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsp(2'd0, 1'b1, 4'hA);
        end
        state("empty", 4, 0);

        // Issue and last response on the same slot in one cycle
        req(4'hA, 2'd0);
        req_valid_i = 1'b1;
        req_id_i    = 4'hA;
        req_q.push_back(2'd0);
        rsp_valid_i = 1'b1;
        rsp_id_i    = 2'd0;
        rsp_last_i  = 1'b1;
        rsp_q.push_back(4'hA);
        tick();
        req_valid_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_last_i  = 1'b0;
        state("simul", 3, 1);
        req(4'h9, 2'd1);
        state("newid", 2, 1);
        rsp(2'd0, 1'b1, 4'hA);
        state("slot0_free", 3, 1);
        rsp(2'd1, 1'b1, 4'h9);
        state("final", 4, 0);

        repeat (2) tick();
        chk("req_q_empty", req_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cluster_id_remapper.md
Name: cluster_id_remapper

Overview:
- Compacts wide AXI IDs into a narrow ID space at the cluster boundary, e.g. NarrowIdWidthOut=4 → 2 bits before the NoC network interface.
- Keeps a slot table mapping each active input ID to one output ID, with a per-slot outstanding-transaction counter.
- Restores the original ID on responses.
- Sits on one AXI direction (AW/B or AR/R); instantiate twice per port.

Parameters:
- InIdWidth, 4, width of incoming request ID.
- OutIdWidth, 2, width of remapped ID; NumSlots = 2**OutIdWidth.
- MaxTxns, 8, max outstanding transactions per slot (≥1).
- CntWidth, $clog2(MaxTxns+1), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- req_id_i  in  InIdWidth  upstream request ID
- req_valid_o  out  1  downstream request valid
- req_ready_i  in  1  downstream request ready
- req_id_o  out  OutIdWidth  remapped ID (slot index)
- rsp_valid_i  in  1  downstream response valid
- rsp_ready_o  out  1  downstream response ready
- rsp_id_i  in  OutIdWidth  response ID (slot index)
- rsp_last_i  in  1  final beat of the transaction (tie 1 for B)
- rsp_valid_o  out  1  upstream response valid
- rsp_ready_i  in  1  upstream response ready
- rsp_id_o  out  InIdWidth  restored original ID
- free_slots_o  out  OutIdWidth+1  number of unallocated slots
- busy_o  out  1  any slot allocated
- stall_cnt_o  out  16  stall statistics (see Optional Feature)

Behaviour:
- State per slot: valid, in_id[InIdWidth], cnt[CntWidth]. Reset: all valid=0, cnt=0; free_slots_o=NumSlots, busy_o=0, stall_cnt_o=0.
- Request path is combinational (0-cycle latency); the only state is the table.
- Slot selection:
  - If a valid slot has in_id==req_id_i: use it (hit). At most one can match (invariant).
  - Hit with cnt==MaxTxns: stall.
  - Miss: allocate the lowest-index slot with valid=0. Miss with no free slot: stall.
- can_issue = !stall. req_valid_o = req_valid_i & can_issue; req_ready_o = req_ready_i & can_issue; req_id_o = selected slot index.
- On req_valid_o & req_ready_i:
  - Selected slot cnt += 1.
  - On a miss, set valid=1 and in_id=req_id_i.
- Once asserted, req_valid_o must not drop while req_ready_i is low. Upstream holds req_id_i stable, so the selection is stable.
- Response path is a pure pass-through: rsp_valid_o = rsp_valid_i, rsp_ready_o = rsp_ready_i, rsp_id_o = table[rsp_id_i].in_id.
- On rsp_valid_i & rsp_ready_i & rsp_last_i: table[rsp_id_i].cnt -= 1. If the result is 0, clear valid in the same edge.
- Simultaneous request issue and last response on the same slot:
  - Net cnt unchanged.
  - If the old cnt was 1, the slot stays valid (hit takes precedence over free).
- A freed slot is not reusable by a miss in the same cycle. Free-slot selection uses registered valid bits.
- Response to a slot with cnt==0 or valid==0 is illegal. The simulation assertion fires, and cnt must not underflow (hold at 0).
- free_slots_o and busy_o are combinational from the registered valid bits.
- Reset mid-operation clears the table in one cycle. The environment must also flush in-flight transactions.
- Same input ID always maps to the same output ID while outstanding, so AXI same-ID ordering is preserved.

Optional Feature:
- Macro CLUSTER_ID_REMAP_STALL_CNT_EN.
- Defined: stall_cnt_o is a 16-bit saturating counter.
  - Increments each cycle with req_valid_i & !can_issue.
  - Saturates at 16'hFFFF; cleared by rst_i.
- Undefined: stall_cnt_o tied to 16'h0 and no counter flops synthesised.

Test Plan:
- Reset, then request ID 4'hA → req_id_o=0, slot0 {valid, A, cnt=1}, free_slots_o=3, busy_o=1.
- Requests with IDs A, 5, A, C, 3 (no responses) → req_id_o = 0,1,0,2,3; free_slots_o=0. A 6th request with ID 7 stalls: req_ready_o=0, req_valid_o=0.
- 8 requests with ID A (MaxTxns=8), then a 9th → the 9th stalls. A last response on slot 0 in the next cycle un-stalls it; cnt stays 8.
- Slot1 holds ID 5 with cnt=1; rsp_id_i=1 with rsp_last_i=1 → rsp_id_o=4'h5, slot1 freed next cycle, free_slots_o increments. With rsp_last_i=0 the slot is not freed.
- Slot0 has cnt=1; issue ID A and a last response on slot 0 in the same cycle → slot0 stays valid, cnt=1, and a new ID does not take slot 0.
- With CLUSTER_ID_REMAP_STALL_CNT_EN and all 4 slots busy, hold req_valid_i for 10 cycles → stall_cnt_o=10. Without the macro → stall_cnt_o=0.
